fact_ctrl: RTL and testbench

//  Control unit for the factorial peripheral: drives the factorial datapath's

---
 rtl/fact_pkg.sv | 22 ++
 rtl/fact_ctrl.sv | 102 ++++++++++
 tb/tb_fact_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial peripheral: controller state encoding
// and the operand range limit used by the datapath's range compare.
package fact_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    MUL,
    DONE,
    ERR
  } fact_state_t;

  // Largest operand whose factorial fits the 32-bit product register.
  localparam int FACT_MAX_N = 12;

  // Rest states are the only ones in which a go request is honoured.
  function automatic logic is_rest(input fact_state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/fact_ctrl.sv
// Control unit for the factorial peripheral. Sequences the datapath's
// down-counter and product register, reports done/err, and counts the
// clock edges spent busy on the most recent accepted request.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             gt_in,
  input  logic             gt_fact,
  output logic             load_cnt,
  output logic             en,
  output logic             sel_1,
  output logic             load_reg,
  output logic             sel_2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  fact_state_t state;
  fact_state_t state_next;
  logic        clr_cycles;

  // State register and busy-cycle counter; reset may land at any time.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cycles <= '0;
    end else begin
      state <= state_next;
      if (clr_cycles) begin
        cycles <= '0;
      end else if (busy && (cycles != '1)) begin
        cycles <= cycles + CNT_W'(1);
      end
    end
  end

  // Next-state logic plus Moore output decode from the state register.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    clr_cycles = 1'b0;
    load_cnt   = 1'b0;
    en         = 1'b0;
    sel_1      = 1'b0;
    load_reg   = 1'b0;
    sel_2      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    // A request is only honoured from a rest state; while busy it is ignored.
    if (is_rest(state) && go) begin
      if (gt_in) begin
        state_next = ERR;
      end else begin
        state_next = LOAD;
        clr_cycles = 1'b1;
      end
    end

    case (state)
      LOAD: begin
        // cnt <= n, prod <= 1
        load_cnt   = 1'b1;
        load_reg   = 1'b1;
        busy       = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = gt_fact ? MUL : DONE;
      end
      MUL: begin
        // prod <= prod * cnt, cnt <= cnt - 1
        load_reg   = 1'b1;
        sel_1      = 1'b1;
        en         = 1'b1;
        busy       = 1'b1;
        state_next = CHECK;
      end
      DONE: begin
        sel_2 = 1'b1;
        done  = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl paired with a behavioural factorial datapath. Two
// controllers share the host stimulus: one at the default counter width and
// one with a 3-bit counter to exercise cycle-count saturation.
module tb_fact_ctrl;
  import fact_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_W_S = 3;

  typedef struct {
    int          n;
    logic [31:0] nf;
    int          cyc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  logic [3:0] n_in = '0;

  always #5 clk = ~clk;

  // Main controller + datapath model
  logic load_cnt, en, sel_1, load_reg, sel_2, busy, done, err;
  logic gt_in, gt_fact;
  logic [CNT_W-1:0] cycles;
  logic [3:0]  cnt;
  logic [31:0] prod, nf;

  // Saturating controller + datapath model
  logic s_load_cnt, s_en, s_sel_1, s_load_reg, s_sel_2, s_busy, s_done, s_err;
  logic s_gt_fact;
  logic [CNT_W_S-1:0] s_cycles;
  logic [3:0]  s_cnt;
  logic [31:0] s_prod, s_nf;

  fact_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .go(go), .gt_in(gt_in), .gt_fact(gt_fact),
    .load_cnt(load_cnt), .en(en), .sel_1(sel_1), .load_reg(load_reg),
    .sel_2(sel_2), .busy(busy), .done(done), .err(err), .cycles(cycles)
  );

  fact_ctrl #(.CNT_W(CNT_W_S)) dut_s (
    .clk(clk), .rst(rst), .go(go), .gt_in(gt_in), .gt_fact(s_gt_fact),
    .load_cnt(s_load_cnt), .en(s_en), .sel_1(s_sel_1), .load_reg(s_load_reg),
    .sel_2(s_sel_2), .busy(s_busy), .done(s_done), .err(s_err), .cycles(s_cycles)
  );

  assign gt_in     = (int'(n_in) > FACT_MAX_N);
  assign gt_fact   = (cnt > 4'd1);
  assign nf        = sel_2 ? prod : 32'd0;
  assign s_gt_fact = (s_cnt > 4'd1);
  assign s_nf      = s_sel_2 ? s_prod : 32'd0;

  // Datapath model for the main controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      prod <= '0;
    end else begin
      if (load_cnt) cnt <= n_in;
      else if (en)  cnt <= cnt - 4'd1;
      if (load_reg) prod <= sel_1 ? prod * 32'(cnt) : 32'd1;
    end
  end

  // Datapath model for the saturating controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt  <= '0;
      s_prod <= '0;
    end else begin
      if (s_load_cnt) s_cnt <= n_in;
      else if (s_en)  s_cnt <= s_cnt - 4'd1;
      if (s_load_reg) s_prod <= s_sel_1 ? s_prod * 32'(s_cnt) : 32'd1;
    end
  end

  // Flags any datapath write strobe, used to prove the reject path writes nothing
  logic saw_load = 1'b0;
  logic clr_saw  = 1'b0;
  always_ff @(posedge clk) begin
    if (clr_saw) saw_load <= 1'b0;
    else if (load_cnt || load_reg) saw_load <= 1'b1;
  end

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  function automatic logic [31:0] fact_of(input int n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * 32'(i);
    return r;
  endfunction

  // Push expectation, pulse go for one cycle from a rest state; returns after the sample edge + 1.
  task automatic issue(input int n);
    exp_t e;
    @(negedge clk);
    n_in = 4'(n);
    go   = 1'b1;
    if (n <= FACT_MAX_N) begin
      e.n   = n;
      e.nf  = fact_of(n);
      e.cyc = (n == 0) ? 2 : 2 * n;
      e.lat = e.cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Wait for done, pop the scoreboard and compare; optionally toggle go while busy.
  task automatic wait_done(input string tag, input bit toggle);
    exp_t e;
    int k = 0;
    int sat;
    while (!done && k < 200) begin
      if (toggle && k == 2) go = 1'b1;
      if (toggle && k == 5) go = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: done=%b after %0d edges, required 1", tag, done, k);
      return;
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty: got done with nothing expected, required an entry", tag);
      return;
    end
    e = sb.pop_front();
    sat = (e.cyc > 7) ? 7 : e.cyc;
    checks++;
    if (nf !== e.nf) begin
      failures++;
      $display("FAIL %s nf n=%0d: got %0d, required %0d", tag, e.n, nf, e.nf);
    end
    checks++;
    if (k != e.lat) begin
      failures++;
      $display("FAIL %s latency n=%0d: got %0d, required %0d", tag, e.n, k, e.lat);
    end
    checks++;
    if (cycles !== CNT_W'(e.cyc)) begin
      failures++;
      $display("FAIL %s cycles n=%0d: got %0d, required %0d", tag, e.n, cycles, e.cyc);
    end
    checks++;
    if (s_done !== 1'b1 || s_nf !== e.nf || s_cycles !== CNT_W_S'(sat)) begin
      failures++;
      $display("FAIL %s sat_unit n=%0d: got done=%b nf=%0d cycles=%0d, required 1 %0d %0d",
               tag, e.n, s_done, s_nf, s_cycles, e.nf, sat);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || sel_2 !== 1'b1) begin
      failures++;
      $display("FAIL %s status: got busy=%b err=%b sel_2=%b, required 0 0 1", tag, busy, err, sel_2);
    end
    // Result must hold while go stays low
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || nf !== e.nf || cycles !== CNT_W'(e.cyc)) begin
      failures++;
      $display("FAIL %s hold: got done=%b nf=%0d cycles=%0d, required 1 %0d %0d",
               tag, done, nf, cycles, e.nf, e.cyc);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({load_cnt, en, sel_1, load_reg, sel_2, busy, done, err} !== 8'b0 ||
        cycles !== '0 || nf !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ctl=%b cycles=%0d nf=%0d, required all 0",
               {load_cnt, en, sel_1, load_reg, sel_2, busy, done, err}, cycles, nf);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || load_cnt !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_go: got busy=%b done=%b err=%b load_cnt=%b, required 0 0 0 0",
               busy, done, err, load_cnt);
    end
  endtask

  task automatic test_basic();
    int ns[4] = '{5, 12, 0, 1};
    foreach (ns[i]) begin
      issue(ns[i]);
      wait_done($sformatf("basic_n%0d", ns[i]), 1'b0);
    end
  endtask

  task automatic test_err(input string tag, input int n);
    @(negedge clk);
    clr_saw = 1'b1;
    @(negedge clk);
    clr_saw = 1'b0;
    issue(n);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || nf !== 32'd0) begin
      failures++;
      $display("FAIL %s reject: got err=%b done=%b busy=%b nf=%0d, required 1 0 0 0",
               tag, err, done, busy, nf);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || saw_load !== 1'b0 || nf !== 32'd0) begin
      failures++;
      $display("FAIL %s hold: got err=%b saw_load=%b nf=%0d, required 1 0 0", tag, err, saw_load, nf);
    end
  endtask

  task automatic test_back_to_back();
    issue(5);
    wait_done("go_during_mul", 1'b1);
    issue(3);
    wait_done("go_from_done", 1'b0);
    test_err("err_mid", 13);
    issue(4);
    wait_done("go_from_err", 1'b0);
  endtask

  task automatic test_async_reset();
    issue(7);
    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || en !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_in_mul: got busy=%b en=%b, required 1 1", busy, en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({load_cnt, en, sel_1, load_reg, sel_2, busy, done, err} !== 8'b0 ||
        cycles !== '0 || nf !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: got ctl=%b cycles=%0d nf=%0d, required all 0",
               {load_cnt, en, sel_1, load_reg, sel_2, busy, done, err}, cycles, nf);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    issue(7);
    wait_done("after_reset_n7", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_err("err_n13", 13);
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
